// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: serialized loads/stores with a fixed
// wait-state count, a stall toward the hazard unit and bad-access flagging.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteEnable,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        resp_valid,
  output logic        err,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  localparam bit ZW = (WAIT_STATES == 0);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, bad_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [7:0]  errcnt_q;
  logic [31:0] mem [2**ADDR_WIDTH];

  // With no wait states the access happens on the capture edge, so it must
  // use the live inputs instead of the not-yet-latched copies.
  logic        a_we, do_acc, bad, legal, half, word;
  logic [31:0] a_addr, a_wdata, shifted;
  logic [3:0]  a_be;
  logic [ADDR_WIDTH-1:0] widx;

  assign a_we    = ZW ? we         : we_q;
  assign a_addr  = ZW ? addr       : addr_q;
  assign a_wdata = ZW ? wdata      : wdata_q;
  assign a_be    = ZW ? byteEnable : be_q;
  assign do_acc  = ZW ? (state_q == IDLE && req_valid) : (state_q == WAIT && cnt_q == 4'd1);
  assign widx    = a_addr[ADDR_WIDTH+1:2];
  assign shifted = a_wdata << {a_addr[1:0], 3'b000};

  always_comb begin
    legal = 1'b0;
    case (a_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign half = (a_be == 4'b0011) || (a_be == 4'b1100);
  assign word = (a_be == 4'b1111);
  assign bad  = ((a_addr >> (ADDR_WIDTH + 2)) != 32'd0) || (half && a_addr[0]) ||
                (word && (a_addr[1:0] != 2'b00)) || !legal;

  // Array is never cleared; clr gating drops a store caught by reset.
  always_ff @(posedge clk) begin
    if (clr && do_acc && a_we && !bad) begin
      for (int k = 0; k < 4; k++)
        if (a_be[k]) mem[widx][8*k +: 8] <= shifted[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      bad_q    <= 1'b0;
      rdata_q  <= 32'd0;
      errcnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_valid) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        be_q    <= byteEnable;
      end
      if (do_acc) begin
        bad_q <= bad;
        if (bad) begin
          rdata_q <= 32'd0;
          if (errcnt_q != 8'hFF) errcnt_q <= errcnt_q + 8'd1;
        end else if (!a_we) begin
          rdata_q <= mem[widx];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          cnt_d   = 4'(WAIT_STATES);
          state_d = ZW ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign resp_valid = (state_q == DONE);
  assign err        = (state_q == DONE) && bad_q;
  assign rdata      = rdata_q;
  assign err_count  = errcnt_q;

endmodule
